// File: rtl/mbs_fsk_demod.sv
// mbsFSK receiver: counts carrier rising edges per symbol window, slices a bit and checks it against the x^5+x^3+1 m-sequence.
// Latency: fsk edge to rise 3 clk, bit_valid 1 clk after window end; free-running with no backpressure.
module mbs_fsk_demod #(
  parameter int SYM_LEN     = 1000,
  parameter int EDGE_THRESH = 6,
  parameter int LOCK_LEN    = 31,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       RSTB,
  input  logic       en,
  input  logic       fsk_in,
  output logic       bit_valid,
  output logic       bit_out,
  output logic [4:0] lfsr,
  output logic [7:0] edge_count,
  output logic       locked,
  output logic [6:0] err_count,
  output logic       busy
);

  localparam int MW = $clog2(LOCK_LEN + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_dly;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_win;
  logic [7:0]       r_acc;
  logic [7:0]       r_last;
  logic             r_end;
  logic [2:0]       r_fill;
  logic [MW-1:0]    r_match;

  logic             w_rise;
  logic             w_win_last;
  logic [7:0]       w_acc_nxt;
  logic             w_bit;
  logic             w_pred;
  logic [MW-1:0]    w_match_inc;
  logic [6:0]       w_err_inc;

  assign w_rise      = r_sync2 & ~r_dly;
  assign w_win_last  = (r_win == CNT_W'(SYM_LEN - 1));
  assign w_acc_nxt   = (w_rise && r_acc != 8'hFF) ? r_acc + 8'd1 : r_acc;
  assign w_bit       = (r_last >= 8'(EDGE_THRESH));
  assign w_pred      = lfsr[4] ^ lfsr[2];
  assign w_match_inc = (r_match == MW'(LOCK_LEN)) ? r_match : r_match + 1'b1;
  assign w_err_inc   = (err_count == 7'h7F) ? err_count : err_count + 7'd1;
  assign busy        = (r_state == ST_RUN);

  always_ff @(posedge clk or negedge RSTB) begin
    if (!RSTB) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= fsk_in;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge RSTB) begin
    if (!RSTB) begin
      r_state    <= ST_IDLE;
      r_win      <= '0;
      r_acc      <= '0;
      r_last     <= '0;
      r_end      <= 1'b0;
      r_fill     <= '0;
      r_match    <= '0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      lfsr       <= '0;
      edge_count <= '0;
      locked     <= 1'b0;
      err_count  <= '0;
    end else if (!en) begin
      // bit_out and edge_count deliberately keep their last values
      r_state   <= ST_IDLE;
      r_win     <= '0;
      r_acc     <= '0;
      r_end     <= 1'b0;
      r_fill    <= '0;
      r_match   <= '0;
      bit_valid <= 1'b0;
      lfsr      <= '0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      bit_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_RUN;
            r_win   <= CNT_W'(1);
            r_acc   <= 8'd1;
          end
        end
        default: begin
          if (w_win_last) begin
            r_win  <= '0;
            r_acc  <= '0;
            r_last <= w_acc_nxt;
            r_end  <= 1'b1;
          end else begin
            r_win  <= r_win + 1'b1;
            r_acc  <= w_acc_nxt;
            r_end  <= 1'b0;
          end
          // Window result is consumed one cycle after the wrap
          if (r_end) begin
            edge_count <= r_last;
            if (r_last == 8'd0) begin
              r_state <= ST_IDLE;
              r_win   <= '0;
              r_acc   <= '0;
              locked  <= 1'b0;
            end else begin
              bit_valid <= 1'b1;
              bit_out   <= w_bit;
              lfsr      <= {lfsr[3:0], w_bit};
              if (r_fill < 3'd5) begin
                r_fill <= r_fill + 3'd1;
              end else if (w_bit == w_pred) begin
                r_match <= w_match_inc;
                if (w_match_inc == MW'(LOCK_LEN)) begin
                  locked <= 1'b1;
                end
              end else begin
                r_match   <= '0;
                locked    <= 1'b0;
                err_count <= w_err_inc;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbs_fsk_demod.sv
// Directed bench for mbs_fsk_demod: windowed edge counting, m-sequence lock, error/relock, carrier loss, en/RSTB drop, boundaries.
// A second instance with a long window covers edge_count saturation.
module tb_mbs_fsk_demod;

  localparam int SYM  = 100;
  localparam int THR  = 8;
  localparam int SYM2 = 520;

  logic clk    = 1'b0;
  logic RSTB   = 1'b1;
  logic en     = 1'b0;
  logic fsk_in = 1'b0;
  logic fsk2   = 1'b0;

  logic       bit_valid, bit_out, locked, busy;
  logic [4:0] lfsr;
  logic [7:0] edge_count;
  logic [6:0] err_count;
  logic       bv2, bo2, lk2, busy2;
  logic [4:0] lfsr2;
  logic [7:0] ec2;
  logic [6:0] err2;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int win_start = 0;
  int seq_start = 0;
  logic tx [0:127];
  int tx_n = 0;

  logic       mon_bit  [0:511];
  logic [4:0] mon_lfsr [0:511];
  logic [7:0] mon_ec   [0:511];
  logic       mon_lock [0:511];
  logic [6:0] mon_err  [0:511];
  int         mon_cyc  [0:511];
  int         mon_n = 0;
  int         sat_n = 0;
  logic [7:0] sat_ec = 8'd0;
  logic       sat_bit = 1'b0;

  mbs_fsk_demod #(.SYM_LEN(SYM), .EDGE_THRESH(THR), .LOCK_LEN(31), .CNT_W(10)) u_dut (
    .clk(clk), .RSTB(RSTB), .en(en), .fsk_in(fsk_in),
    .bit_valid(bit_valid), .bit_out(bit_out), .lfsr(lfsr), .edge_count(edge_count),
    .locked(locked), .err_count(err_count), .busy(busy)
  );

  mbs_fsk_demod #(.SYM_LEN(SYM2), .EDGE_THRESH(THR), .LOCK_LEN(31), .CNT_W(10)) u_sat (
    .clk(clk), .RSTB(RSTB), .en(en), .fsk_in(fsk2),
    .bit_valid(bv2), .bit_out(bo2), .lfsr(lfsr2), .edge_count(ec2),
    .locked(lk2), .err_count(err2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bit_valid && mon_n < 512) begin
      mon_bit[mon_n]  <= bit_out;
      mon_lfsr[mon_n] <= lfsr;
      mon_ec[mon_n]   <= edge_count;
      mon_lock[mon_n] <= locked;
      mon_err[mon_n]  <= err_count;
      mon_cyc[mon_n]  <= cyc;
      mon_n           <= mon_n + 1;
    end
    if (bv2) begin
      sat_n   <= sat_n + 1;
      sat_ec  <= ec2;
      sat_bit <= bo2;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One symbol window of square carrier; the first rise lands on window cycle 0
  task automatic drive_win(input int period);
    for (int c = 0; c < SYM; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) win_start = cyc;
      fsk_in = ((c % period) < (period / 2));
    end
  endtask

  task automatic drive_rises(input int r0, input int r1);
    for (int c = 0; c < SYM; c++) begin
      @(posedge clk);
      #1;
      fsk_in = (c == r0) || (c == r1);
    end
  endtask

  task automatic send_bits();
    for (int i = 0; i < tx_n; i++) begin
      drive_win(tx[i] ? 10 : 20);
      if (i == 0) seq_start = win_start;
    end
    fsk_in = 1'b0;
  endtask

  task automatic en_toggle();
    @(posedge clk);
    #1 en = 1'b0;
    wait_cyc(2);
    #1 en = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_reset();
    #2 RSTB = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    checks++;
    if ({bit_valid, bit_out, lfsr, edge_count, locked, err_count, busy, busy2} !== 25'd0) begin
      errors++;
      $display("FAIL reset: outputs %b, required all zero",
               {bit_valid, bit_out, lfsr, edge_count, locked, err_count, busy, busy2});
    end
    @(posedge clk);
    #1 RSTB = 1'b1;
    en = 1'b1;
    wait_cyc(3);
  endtask

  task automatic test_basic();
    int base;
    int exp_ec [5] = '{10, 10, 10, 5, 5};
    logic exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    base = mon_n;
    tx_n = 5;
    for (int i = 0; i < 5; i++) tx[i] = exp_b[i];
    send_bits();
    wait_cyc(10);
    @(negedge clk);
    checks++;
    if (mon_n - base != 5) begin
      errors++;
      $display("FAIL basic count: got %0d bit_valid, required 5", mon_n - base);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mon_bit[base+i], mon_ec[base+i]} !== {exp_b[i], 8'(exp_ec[i])} ||
          mon_cyc[base+i] != seq_start + 103 + 100 * i) begin
        errors++;
        $display("FAIL basic bit %0d: got bit %b ec %0d cyc %0d, required bit %b ec %0d cyc %0d",
                 i, mon_bit[base+i], mon_ec[base+i], mon_cyc[base+i] - seq_start,
                 exp_b[i], exp_ec[i], 103 + 100 * i);
      end
    end
    checks++;
    if ({mon_lfsr[base+4], mon_err[base+4], busy} !== {5'b11100, 7'd0, 1'b1}) begin
      errors++;
      $display("FAIL basic lfsr/err/busy: got %b %0d %b, required 11100 0 1",
               mon_lfsr[base+4], mon_err[base+4], busy);
    end
    wait_cyc(250);
    @(negedge clk);
    checks++;
    if ({busy, edge_count} !== 9'd0 || mon_n - base != 5) begin
      errors++;
      $display("FAIL basic idle: got busy %b ec %0d events %0d, required 0 0 5",
               busy, edge_count, mon_n - base);
    end
  endtask

  task automatic test_sequence();
    int base;
    logic [4:0] st;
    en_toggle();
    base = mon_n;
    tx_n = 67;
    for (int i = 0; i < tx_n; i++) begin
      if (i < 5) tx[i] = (i == 4);
      else tx[i] = tx[i-5] ^ tx[i-3];
    end
    send_bits();
    wait_cyc(10);
    @(negedge clk);
    checks++;
    if (mon_n - base != tx_n) begin
      errors++;
      $display("FAIL seq count: got %0d, required %0d", mon_n - base, tx_n);
    end
    st = 5'd0;
    for (int i = 0; i < tx_n; i++) begin
      st = {st[3:0], tx[i]};
      checks++;
      if ({mon_bit[base+i], mon_lfsr[base+i], mon_lock[base+i], mon_err[base+i]} !==
          {tx[i], st, (i + 1 >= 36), 7'd0}) begin
        errors++;
        $display("FAIL seq bit %0d: got bit/lfsr/lock/err %b, required %b", i + 1,
                 {mon_bit[base+i], mon_lfsr[base+i], mon_lock[base+i], mon_err[base+i]},
                 {tx[i], st, (i + 1 >= 36), 7'd0});
      end
    end
  endtask

  task automatic test_carrier_loss();
    int base;
    base = mon_n;
    wait_cyc(250);
    @(negedge clk);
    checks++;
    if ({busy, locked, edge_count} !== 10'd0 || mon_n != base) begin
      errors++;
      $display("FAIL loss: got busy %b locked %b ec %0d events %0d, required 0 0 0 0",
               busy, locked, edge_count, mon_n - base);
    end
    wait_cyc(37);
    drive_win(10);
    fsk_in = 1'b0;
    wait_cyc(10);
    @(negedge clk);
    checks++;
    if (mon_n - base != 1 || mon_cyc[base] != win_start + 103 || mon_ec[base] !== 8'd10) begin
      errors++;
      $display("FAIL loss restart: got events %0d cyc %0d ec %0d, required 1 103 10",
               mon_n - base, mon_cyc[base] - win_start, mon_ec[base]);
    end
    wait_cyc(250);
  endtask

  task automatic test_error_relock();
    int base;
    logic [4:0] st;
    logic el;
    logic [6:0] ee;
    en_toggle();
    base = mon_n;
    tx_n = 75;
    for (int i = 0; i < tx_n; i++) begin
      if (i < 5) tx[i] = (i == 4);
      else tx[i] = tx[i-5] ^ tx[i-3];
      if (i == 39) tx[i] = ~tx[i];
    end
    send_bits();
    wait_cyc(10);
    @(negedge clk);
    checks++;
    if (mon_n - base != tx_n) begin
      errors++;
      $display("FAIL relock count: got %0d, required %0d", mon_n - base, tx_n);
    end
    st = 5'd0;
    for (int i = 0; i < tx_n; i++) begin
      st = {st[3:0], tx[i]};
      el = ((i + 1 >= 36) && (i + 1 < 40)) || (i + 1 >= 71);
      ee = (i + 1 >= 40) ? 7'd1 : 7'd0;
      checks++;
      if ({mon_bit[base+i], mon_lfsr[base+i], mon_lock[base+i], mon_err[base+i]} !==
          {tx[i], st, el, ee}) begin
        errors++;
        $display("FAIL relock bit %0d: got bit/lfsr/lock/err %b, required %b", i + 1,
                 {mon_bit[base+i], mon_lfsr[base+i], mon_lock[base+i], mon_err[base+i]},
                 {tx[i], st, el, ee});
      end
    end
    wait_cyc(250);
  endtask

  task automatic test_en_drop();
    int base;
    base = mon_n;
    fork
      begin
        repeat (3) drive_win(10);
      end
      begin
        repeat (252) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({locked, err_count, lfsr} !== 13'd0) begin
          errors++;
          $display("FAIL en drop clear: got locked %b err %0d lfsr %b, required 0 0 00000",
                   locked, err_count, lfsr);
        end
        checks++;
        if ({bit_out, edge_count, busy} !== {1'b1, 8'd10, 1'b0}) begin
          errors++;
          $display("FAIL en drop hold: got bit %b ec %0d busy %b, required 1 10 0",
                   bit_out, edge_count, busy);
        end
      end
    join
    fsk_in = 1'b0;
    wait_cyc(5);
    #1 en = 1'b1;
    wait_cyc(250);
    @(negedge clk);
    checks++;
    if (mon_n - base != 2 || {busy, bit_out} !== 2'b01) begin
      errors++;
      $display("FAIL en drop after: got events %0d busy %b bit %b, required 2 0 1",
               mon_n - base, busy, bit_out);
    end
  endtask

  task automatic test_rstb_drop();
    int base;
    base = mon_n;
    fork
      begin
        repeat (2) drive_win(10);
      end
      begin
        repeat (151) @(posedge clk);
        #2 RSTB = 1'b0;
        #1;
        checks++;
        if ({bit_valid, bit_out, lfsr, edge_count, locked, err_count, busy} !== 24'd0) begin
          errors++;
          $display("FAIL rstb drop: outputs %b, required all zero",
                   {bit_valid, bit_out, lfsr, edge_count, locked, err_count, busy});
        end
      end
    join
    fsk_in = 1'b0;
    wait_cyc(5);
    #1 RSTB = 1'b1;
    wait_cyc(250);
    @(negedge clk);
    checks++;
    if (mon_n - base != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstb after: got events %0d busy %b, required 1 0", mon_n - base, busy);
    end
  endtask

  task automatic test_boundary();
    int base;
    int exp_ec [3] = '{2, 1, 2};
    base = mon_n;
    drive_rises(0, SYM - 1);
    drive_rises(50, -1);
    drive_rises(0, 20);
    fsk_in = 1'b0;
    wait_cyc(10);
    @(negedge clk);
    checks++;
    if (mon_n - base != 3) begin
      errors++;
      $display("FAIL boundary count: got %0d, required 3", mon_n - base);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mon_bit[base+i], mon_ec[base+i]} !== {1'b0, 8'(exp_ec[i])}) begin
        errors++;
        $display("FAIL boundary win %0d: got bit %b ec %0d, required 0 %0d",
                 i, mon_bit[base+i], mon_ec[base+i], exp_ec[i]);
      end
    end
    wait_cyc(250);
  endtask

  task automatic test_saturation();
    for (int c = 0; c < SYM2; c++) begin
      @(posedge clk);
      #1;
      fsk2 = ((c % 2) == 0);
    end
    fsk2 = 1'b0;
    wait_cyc(10);
    @(negedge clk);
    checks++;
    if (sat_n != 1 || {sat_bit, sat_ec} !== {1'b1, 8'd255}) begin
      errors++;
      $display("FAIL saturation: got events %0d bit %b ec %0d, required 1 1 255",
               sat_n, sat_bit, sat_ec);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_carrier_loss();
    test_error_relock();
    test_en_drop();
    test_rstb_drop();
    test_boundary();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbs_fsk_demod.md
Name: mbs_fsk_demod

Overview:
- Receive-side counterpart of the mbsFSK transmitter.
- Takes the single-bit FSK waveform from an mprj_io pin and recovers one data bit per symbol window by counting carrier rising edges.
- Checks the recovered bitstream against the 5-bit maximal-length sequence (x^5+x^3+1, period 31) and reports lock, LFSR state and error count on user GPIO outputs.

Parameters:
SYM_LEN, 1000, clock cycles per symbol window (>=16)
EDGE_THRESH, 6, edges per window at or above which bit = 1
LOCK_LEN, 31, consecutive matching bits required to assert locked
CNT_W, 10, width of window counter (2^CNT_W >= SYM_LEN)

Ports:
clk  input  1  system clock
RSTB  input  1  asynchronous active-low reset
en  input  1  demodulator enable; low = held in IDLE, counters cleared
fsk_in  input  1  asynchronous FSK carrier from pad
bit_valid  output  1  one-cycle pulse, new bit on bit_out
bit_out  output  1  recovered bit, held until next bit_valid
lfsr  output  5  last 5 recovered bits, newest in [0]
edge_count  output  8  edges counted in last completed window, saturating at 255
locked  output  1  sequence lock indicator
err_count  output  7  mismatches since enable, saturating at 127
busy  output  1  high in RUN state

Behaviour:
- Reset (RSTB low, async): all outputs 0; state IDLE; synchroniser flops, window counter, fill counter and match counter 0.
- Input path: fsk_in -> 2-flop synchroniser -> delay flop. rise = sync & ~delay, one cycle per carrier rising edge. Edge-to-rise latency is 3 clk.
- en low in any state:
  - next cycle returns to IDLE.
  - Clears lfsr, fill, match, err_count and locked.
  - bit_out and edge_count hold their values.
- IDLE:
  - busy=0.
  - On rise with en=1: go to RUN, window counter=1, edge accumulator=1. That edge counts toward the first window.
- RUN:
  - busy=1. Window counter increments each cycle; edge accumulator increments on rise, saturating at 255.
  - Last window cycle is counter==SYM_LEN-1; a rise in that cycle counts in the current window.
  - End of window: counter wraps to 0, accumulator restarts at 0 (or 1 if rise arrives in the first cycle of the next window).
  - One cycle after window end:
    - edge_count <= accumulated count.
    - If count==0 (carrier loss): go to IDLE, locked <= 0, no bit_valid.
    - Otherwise: bit_out <= (count >= EDGE_THRESH); bit_valid pulses for 1 cycle; lfsr <= {lfsr[3:0], bit}.
- Sequence checker, per bit_valid, using lfsr before the shift:
  - Fill: while fill < 5, fill++ and no comparison.
  - Prediction: pred = lfsr[4] ^ lfsr[2].
  - Match: match counter +1, saturating at LOCK_LEN. locked <= 1 when the counter reaches LOCK_LEN.
  - Mismatch: match counter <= 0, locked <= 0, err_count +1 (saturating at 127).
  - Pre-lock mismatches also count toward err_count.
- All-zero lfsr after fill is a legal state; it predicts 0. Continuous zeros therefore match. Lock validity is left to software.
- Outputs are registered. bit_valid, bit_out, lfsr, locked and err_count update in the same cycle.
- Re-enable after IDLE waits for a fresh rise. Window phase is re-established from that edge.

Test Plan:
1. SYM_LEN=100, EDGE_THRESH=8. Carrier period 10 clk (10 edges/window) for 3 windows, then period 20 (5 edges) for 2 windows -> bit_valid pulses 100 clk apart; bits 1,1,1,0,0; edge_count 10,10,10,5,5.
2. Transmit full 31-bit m-sequence from seed 5'b00001, repeated twice -> err_count=0; locked rises at bit_valid number 5+31=36; lfsr tracks expected sequence.
3. Locked stream with bit 40 inverted -> locked drops on that bit_valid; err_count=1; locked reasserts 31 matching bits later.
4. Carrier stops mid-stream for >1 window -> next window end yields no bit_valid; busy=0; locked=0; next edge restarts RUN with a new window phase.
5. en or RSTB dropped mid-window -> RSTB clears all outputs immediately. en clears lock/err/lfsr next cycle, holds bit_out. No spurious bit_valid either way.
6. Edge on cycle SYM_LEN-1 and on cycle 0 of the next window -> counted in the respective windows. With >255 edges, edge_count=255.
